counter_stimulus_gen: RTL and testbench

- Stimulus generator for the 4-bit multi-mode counter.
- Drives the ENABLE/D/MODO interface that the counter and the scoreboard consume.
- On each start it plays a fixed four-mode transaction sequence: load, run, idle gap per mode.
- Data is LFSR-pseudo-random, with forced boundary values so every RCO condition is hit.

---
 rtl/counter_stimulus_gen.sv | 129 ++++++++++++
 tb/tb_counter_stimulus_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/counter_stimulus_gen.sv
// Stimulus generator for the 4-bit multi-mode counter.
// Each start plays four modes (00, 01, 10, 11) as LOAD -> RUN -> GAP, then pulses done.
module counter_stimulus_gen #(
  parameter int         CYCLES_PER_MODE = 8,
  parameter int         IDLE_GAP        = 2,
  parameter logic [7:0] SEED            = 8'hA5
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       start,
  output logic       ENABLE,
  output logic [3:0] D,
  output logic [1:0] MODO,
  output logic       busy,
  output logic       done,
  output logic [7:0] txn_count
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, GAP, DONE} state_t;

  localparam logic [7:0] RUN_LAST = 8'(CYCLES_PER_MODE - 1);
  localparam logic [7:0] GAP_LAST = 8'(IDLE_GAP - 1);
  localparam bit         HAS_GAP  = (IDLE_GAP != 0);

  state_t     state;
  logic [7:0] lfsr;
  logic [7:0] cnt;
  logic [1:0] mode_idx;

  logic [7:0] lfsr_nxt;
  logic [7:0] lfsr_use;
  logic [3:0] first_d;
  logic       advance;

  // lfsr holds the value whose low nibble drives D in the current cycle;
  // it steps only when the current cycle has ENABLE high.
  assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign lfsr_use = ENABLE ? lfsr_nxt : lfsr;

  assign advance = ((state == RUN) && (cnt == RUN_LAST) && !HAS_GAP) ||
                   ((state == GAP) && (cnt == GAP_LAST));

  // Boundary values on the first RUN cycle so every RCO condition is reached.
  always_comb begin
    first_d = lfsr_use[3:0];
    case (mode_idx)
      2'b00:   first_d = 4'd12;
      2'b01:   first_d = 4'd0;
      2'b10:   first_d = 4'd15;
      default: first_d = lfsr_use[3:0];
    endcase
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      ENABLE    <= 1'b0;
      D         <= 4'd0;
      MODO      <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
      txn_count <= 8'd0;
      lfsr      <= SEED;
      mode_idx  <= 2'b00;
      cnt       <= 8'd0;
    end else begin
      lfsr <= lfsr_use;
      if (ENABLE && (txn_count != 8'hFF))
        txn_count <= txn_count + 8'd1;

      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            lfsr      <= SEED;
            txn_count <= 8'd0;
            mode_idx  <= 2'b00;
            ENABLE    <= 1'b1;
            MODO      <= 2'b11;
            D         <= SEED[3:0];
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          state <= RUN;
          cnt   <= 8'd0;
          MODO  <= mode_idx;
          D     <= first_d;
        end
        RUN: begin
          if (cnt != RUN_LAST) begin
            cnt <= cnt + 8'd1;
            D   <= lfsr_use[3:0];
          end else if (HAS_GAP) begin
            state  <= GAP;
            cnt    <= 8'd0;
            ENABLE <= 1'b0;
          end
        end
        GAP: begin
          if (cnt != GAP_LAST)
            cnt <= cnt + 8'd1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // End of a mode: either load the next one or finish the sequence.
      if (advance) begin
        if (mode_idx != 2'b11) begin
          mode_idx <= mode_idx + 2'b01;
          state    <= LOAD;
          ENABLE   <= 1'b1;
          MODO     <= 2'b11;
          D        <= lfsr_use[3:0];
        end else begin
          state  <= DONE;
          ENABLE <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_stimulus_gen.sv
// Scoreboard bench for counter_stimulus_gen: a trace model fills a queue of
// expected per-cycle outputs, which are popped and compared each cycle.
module tb_counter_stimulus_gen;

  localparam logic [7:0] SEED = 8'hA5;

  logic       clk;
  logic       RESET;
  logic       start, start2;
  logic       enable0, enable1;
  logic [3:0] d0, d1;
  logic [1:0] modo0, modo1;
  logic       busy0, busy1;
  logic       done0, done1;
  logic [7:0] txn0, txn1;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];
  logic [3:0]  model_d;
  logic [1:0]  model_modo;
  logic [7:0]  model_txn;

  counter_stimulus_gen #(.CYCLES_PER_MODE(8), .IDLE_GAP(2), .SEED(SEED)) dut (
    .clk(clk), .RESET(RESET), .start(start),
    .ENABLE(enable0), .D(d0), .MODO(modo0),
    .busy(busy0), .done(done0), .txn_count(txn0)
  );

  counter_stimulus_gen #(.CYCLES_PER_MODE(1), .IDLE_GAP(0), .SEED(SEED)) dut2 (
    .clk(clk), .RESET(RESET), .start(start2),
    .ENABLE(enable1), .D(d1), .MODO(modo1),
    .busy(busy1), .done(done1), .txn_count(txn1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packing: {ENABLE[16], D[15:12], MODO[11:10], busy[9], done[8], txn_count[7:0]}
  function automatic logic [31:0] sample(input int sel);
    if (sel == 0) return {15'd0, enable0, d0, modo0, busy0, done0, txn0};
    else          return {15'd0, enable1, d1, modo1, busy1, done1, txn1};
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input logic en, input logic [3:0] d, input logic [1:0] modo,
                         input logic bsy, input logic dn);
    exp_q.push_back({15'd0, en, d, modo, bsy, dn, model_txn});
    model_d    = d;
    model_modo = modo;
    if (en && model_txn != 8'hFF) model_txn = model_txn + 8'd1;
  endtask

  task automatic pushIdle(input int n);
    for (int i = 0; i < n; i++) pushExp(1'b0, model_d, model_modo, 1'b0, 1'b0);
  endtask

  // Expected trace from the first LOAD cycle through the DONE cycle.
  task automatic pushSequence(input int cpm, input int gap);
    logic [7:0] l;
    logic [3:0] d;
    l = SEED;
    model_txn = 8'd0;
    for (int m = 0; m < 4; m++) begin
      pushExp(1'b1, l[3:0], 2'b11, 1'b1, 1'b0);
      l = lfsr_step(l);
      for (int r = 0; r < cpm; r++) begin
        if (r == 0)
          case (m)
            0:       d = 4'd12;
            1:       d = 4'd0;
            2:       d = 4'd15;
            default: d = l[3:0];
          endcase
        else
          d = l[3:0];
        pushExp(1'b1, d, 2'(m), 1'b1, 1'b0);
        l = lfsr_step(l);
      end
      for (int g = 0; g < gap; g++) pushExp(1'b0, model_d, model_modo, 1'b1, 1'b0);
    end
    pushExp(1'b0, model_d, model_modo, 1'b0, 1'b1);
  endtask

  task automatic setStart(input int sel, input logic v);
    if (sel == 0) start = v;
    else          start2 = v;
  endtask

  task automatic applyStimulus(input int sel);
    @(negedge clk);
    setStart(sel, 1'b1);
  endtask

  // Pops one expectation per cycle; cycle 1 is the cycle after the start edge.
  task automatic drainQueue(input int sel, input int release_at, input int pulse_at,
                            input int stop_at, output int done_at, output int gap_cycles);
    int cycle;
    logic [31:0] o;
    cycle      = 0;
    done_at    = 0;
    gap_cycles = 0;
    while (exp_q.size() > 0 && (stop_at == 0 || cycle < stop_at)) begin
      @(posedge clk);
      #1;
      cycle++;
      if (cycle == release_at) setStart(sel, 1'b0);
      if (pulse_at != 0 && cycle == pulse_at) setStart(sel, 1'b1);
      if (pulse_at != 0 && cycle == pulse_at + 1) setStart(sel, 1'b0);
      o = sample(sel);
      checkOutput($sformatf("dut%0d cycle %0d", sel, cycle), o, exp_q.pop_front());
      if (o[8] && done_at == 0) done_at = cycle;
      if (o[9] && !o[16]) gap_cycles++;
    end
  endtask

  initial begin
    int done_at, gaps;
    start  = 1'b0;
    start2 = 1'b0;
    RESET  = 1'b0;
    model_d = 4'd0; model_modo = 2'b00; model_txn = 8'd0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset dut0", sample(0), 32'd0);
    checkOutput("reset dut1", sample(1), 32'd0);
    @(negedge clk);
    RESET = 1'b1;
    pushIdle(2);
    drainQueue(0, 0, 0, 0, done_at, gaps);

    $display("[TB] single start, default parameters");
    applyStimulus(0);
    pushSequence(8, 2);
    pushIdle(1);
    drainQueue(0, 1, 0, 0, done_at, gaps);
    checkOutput("done cycle", 32'(done_at), 32'd45);
    checkOutput("gap cycles", 32'(gaps), 32'd8);

    $display("[TB] start pulse during mode-01 RUN");
    applyStimulus(0);
    pushSequence(8, 2);
    pushIdle(1);
    drainQueue(0, 1, 15, 0, done_at, gaps);
    checkOutput("done cycle busy-start", 32'(done_at), 32'd45);

    $display("[TB] asynchronous abort during mode-10 RUN");
    applyStimulus(0);
    pushSequence(8, 2);
    drainQueue(0, 1, 0, 26, done_at, gaps);
    exp_q.delete();
    #2;
    RESET = 1'b0;
    #1;
    checkOutput("abort async", sample(0), 32'd0);
    @(negedge clk);
    RESET = 1'b1;
    model_d = 4'd0; model_modo = 2'b00; model_txn = 8'd0;
    pushIdle(4);
    drainQueue(0, 0, 0, 0, done_at, gaps);

    $display("[TB] IDLE_GAP=0, CYCLES_PER_MODE=1");
    applyStimulus(1);
    pushSequence(1, 0);
    pushIdle(1);
    drainQueue(1, 1, 0, 0, done_at, gaps);
    checkOutput("done cycle short", 32'(done_at), 32'd9);
    checkOutput("gap cycles short", 32'(gaps), 32'd0);

    $display("[TB] start held high across two sequences");
    model_d = 4'd0; model_modo = 2'b00; model_txn = 8'd0;
    applyStimulus(0);
    pushSequence(8, 2);
    pushIdle(1);
    pushSequence(8, 2);
    pushIdle(2);
    drainQueue(0, 60, 0, 0, done_at, gaps);
    checkOutput("done cycle b2b", 32'(done_at), 32'd45);
    checkOutput("gap cycles b2b", 32'(gaps), 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
